// File: rtl/sprite_pool_if.sv
// Handshake and query bus of the sprite pool: spawn request, point-hit query,
// kill/escape reports and the renderer's per-pixel query.
interface sprite_pool_if #(
  parameter int COORD_W = 10,
  parameter int IDX_W   = 5,
  parameter int CNT_W   = 6
);
  // Spawn handshake: a request transfers on a clk edge where spawn_valid and
  // spawn_ready are both high; spawn_ready never depends on spawn_valid.
  logic               spawn_valid;
  logic               spawn_ready;
  logic [COORD_W-1:0] spawn_row;
  logic               hit_valid;
  logic [COORD_W-1:0] hit_col;
  logic [COORD_W-1:0] hit_row;
  logic               kill;
  logic [IDX_W-1:0]   kill_idx;
  logic               escape;
  logic [CNT_W-1:0]   escape_cnt;
  logic [COORD_W-1:0] pix_col;
  logic [COORD_W-1:0] pix_row;
  logic               pix_hit;
  logic [IDX_W-1:0]   pix_idx;
  logic [COORD_W-1:0] pix_dx;
  logic [COORD_W-1:0] pix_dy;

  modport master (
    output spawn_valid, spawn_row, hit_valid, hit_col, hit_row, pix_col, pix_row,
    input  spawn_ready, kill, kill_idx, escape, escape_cnt,
           pix_hit, pix_idx, pix_dx, pix_dy
  );

  modport slave (
    input  spawn_valid, spawn_row, hit_valid, hit_col, hit_row, pix_col, pix_row,
    output spawn_ready, kill, kill_idx, escape, escape_cnt,
           pix_hit, pix_idx, pix_dx, pix_dy
  );
endinterface

// File: rtl/sprite_pool.sv
// Pool of moving rectangular game objects: spawn, per-frame horizontal motion,
// escape retirement, point-hit kills and a one-cycle per-pixel render query.
module sprite_pool #(
  parameter int SLOTS   = 32,
  parameter int COORD_W = 10,
  parameter int OBJ_W   = 50,
  parameter int OBJ_H   = 40,
  parameter int MIN_C   = 144,
  parameter int MAX_C   = 783,
  parameter int DIR     = 0,
  parameter int SPEED_W = 4,
  parameter int IDX_W   = $clog2(SLOTS),
  parameter int CNT_W   = $clog2(SLOTS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               clear,
  input  logic [SPEED_W-1:0] speed,
  output logic [CNT_W-1:0]   active_cnt,
  sprite_pool_if.slave       bus
);
  localparam int XW = COORD_W + 1;

  logic [SLOTS-1:0]   valid;
  logic [COORD_W-1:0] col [SLOTS];
  logic [COORD_W-1:0] row [SLOTS];

  logic               free_any, hit_any, pix_any;
  logic [IDX_W-1:0]   free_idx, hit_idx, pix_sel;
  logic [SLOTS-1:0]   esc;
  logic [CNT_W-1:0]   esc_cnt, pop_cnt;
  logic               tick_go, hit_go, spawn_go;
  logic [XW-1:0]      spd_x;

  // Box extents are summed one bit wider so objects near the right/bottom edge
  // of the coordinate range do not wrap.
  function automatic logic in_box(input logic v,
                                  input logic [COORD_W-1:0] c, r, x, y);
    logic [XW-1:0] c_end, r_end;
    c_end = {1'b0, c} + XW'(OBJ_W);
    r_end = {1'b0, r} + XW'(OBJ_H);
    return v && (x >= c) && ({1'b0, x} < c_end) && (y >= r) && ({1'b0, y} < r_end);
  endfunction

  assign bus.spawn_ready = enable & ~clear & free_any;
  assign spawn_go        = bus.spawn_valid & bus.spawn_ready;
  assign tick_go         = frame_tick & enable;
  assign hit_go          = bus.hit_valid & enable & hit_any;
  assign spd_x           = XW'(speed);

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    pix_any  = 1'b0;
    pix_sel  = '0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!valid[s]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(s);
      end
      if (in_box(valid[s], col[s], row[s], bus.hit_col, bus.hit_row)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(s);
      end
      if (in_box(valid[s], col[s], row[s], bus.pix_col, bus.pix_row)) begin
        pix_any = 1'b1;
        pix_sel = IDX_W'(s);
      end
    end
  end

  always_comb begin
    esc     = '0;
    esc_cnt = '0;
    pop_cnt = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (DIR == 0)
        esc[s] = valid[s] && tick_go && (speed != '0) &&
                 ({1'b0, col[s]} < (XW'(MIN_C) + spd_x));
      else
        esc[s] = valid[s] && tick_go && (speed != '0) &&
                 (({1'b0, col[s]} + spd_x) > XW'(MAX_C));
      // A slot that is both hit and escaping is reported as a kill only.
      if (esc[s] && !(hit_go && hit_idx == IDX_W'(s)))
        esc_cnt = esc_cnt + 1'b1;
      if (valid[s])
        pop_cnt = pop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid          <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        col[s] <= '0;
        row[s] <= '0;
      end
      bus.kill       <= 1'b0;
      bus.kill_idx   <= '0;
      bus.escape     <= 1'b0;
      bus.escape_cnt <= '0;
    end else if (clear) begin
      valid          <= '0;
      bus.kill       <= 1'b0;
      bus.escape     <= 1'b0;
      bus.escape_cnt <= '0;
    end else if (enable) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (hit_go && hit_idx == IDX_W'(s)) begin
          valid[s] <= 1'b0;
        end else if (esc[s]) begin
          valid[s] <= 1'b0;
        end else if (valid[s] && tick_go) begin
          if (DIR == 0) col[s] <= col[s] - COORD_W'(speed);
          else          col[s] <= col[s] + COORD_W'(speed);
        end
        // Only free slots are spawned into, so this never collides with the above.
        if (spawn_go && free_idx == IDX_W'(s)) begin
          valid[s] <= 1'b1;
          row[s]   <= bus.spawn_row;
          col[s]   <= (DIR == 0) ? COORD_W'(MAX_C) : COORD_W'(MIN_C);
        end
      end
      bus.kill <= hit_go;
      if (hit_go) bus.kill_idx <= hit_idx;
      bus.escape <= tick_go && (esc_cnt != '0);
      if (tick_go) bus.escape_cnt <= esc_cnt;
    end else begin
      bus.kill   <= 1'b0;
      bus.escape <= 1'b0;
    end
  end

  // Render query and occupancy keep running regardless of enable/clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pix_hit <= 1'b0;
      bus.pix_idx <= '0;
      bus.pix_dx  <= '0;
      bus.pix_dy  <= '0;
      active_cnt  <= '0;
    end else begin
      bus.pix_hit <= pix_any;
      bus.pix_idx <= pix_any ? pix_sel : '0;
      bus.pix_dx  <= pix_any ? (bus.pix_col - col[pix_sel]) : '0;
      bus.pix_dy  <= pix_any ? (bus.pix_row - row[pix_sel]) : '0;
      active_cnt  <= pop_cnt;
    end
  end
endmodule

// File: tb/tb_sprite_pool.sv
// Self-checking bench for sprite_pool with default parameters (32 slots, DIR=0).
module tb_sprite_pool;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] speed = '0;
  logic [5:0] active_cnt;

  sprite_pool_if #(.COORD_W(10), .IDX_W(5), .CNT_W(6)) bus ();

  sprite_pool dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .enable     (enable),
    .clear      (clear),
    .speed      (speed),
    .active_cnt (active_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input string tag, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d with no expectation queued", tag, got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input int r);
    bus.spawn_valid = 1'b1;
    bus.spawn_row   = 10'(r);
    step();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic pix_query(input string tag, input int x, input int y,
                           input int e_hit, input int e_idx, input int e_dx, input int e_dy);
    bus.pix_col = 10'(x);
    bus.pix_row = 10'(y);
    sb_push(W'(e_hit)); sb_push(W'(e_idx)); sb_push(W'(e_dx)); sb_push(W'(e_dy));
    step();
    sb_pop({tag, "_hit"}, W'(bus.pix_hit));
    sb_pop({tag, "_idx"}, W'(bus.pix_idx));
    sb_pop({tag, "_dx"},  W'(bus.pix_dx));
    sb_pop({tag, "_dy"},  W'(bus.pix_dy));
  endtask

  task automatic reset_outputs(input string tag);
    sb_push(0); sb_pop({tag, "_active"},  W'(active_cnt));
    sb_push(0); sb_pop({tag, "_kill"},    W'(bus.kill));
    sb_push(0); sb_pop({tag, "_killidx"}, W'(bus.kill_idx));
    sb_push(0); sb_pop({tag, "_escape"},  W'(bus.escape));
    sb_push(0); sb_pop({tag, "_esccnt"},  W'(bus.escape_cnt));
    sb_push(0); sb_pop({tag, "_pixhit"},  W'(bus.pix_hit));
    sb_push(0); sb_pop({tag, "_pixdx"},   W'(bus.pix_dx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int rows[6];
    bus.spawn_valid = 1'b0;
    bus.spawn_row   = '0;
    bus.hit_valid   = 1'b0;
    bus.hit_col     = '0;
    bus.hit_row     = '0;
    bus.pix_col     = '0;
    bus.pix_row     = '0;

    // Reset state
    #12;
    reset_outputs("reset");
    sb_push(0); sb_pop("ready_dis", W'(bus.spawn_ready));
    enable = 1'b1;
    #1;
    sb_push(1); sb_pop("ready_en", W'(bus.spawn_ready));
    @(negedge clk);
    rst = 1'b1;
    step();

    // Fill all 32 slots with spawn_valid held for 33 cycles
    accepts = 0;
    bus.spawn_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      bus.spawn_row = 10'(i * 30);
      #1;
      if (bus.spawn_ready) accepts++;
      step();
    end
    bus.spawn_valid = 1'b0;
    sb_push(32); sb_pop("fill_accepts", W'(accepts));
    sb_push(0);  sb_pop("fill_ready", W'(bus.spawn_ready));
    step();
    sb_push(32); sb_pop("fill_active", W'(active_cnt));
    for (int i = 0; i < 32; i++)
      pix_query($sformatf("fill_pix%0d", i), 783, i * 30 + 35, 1, i, 0, 35);
    pix_query("fill_left_miss", 782, 35, 0, 0, 0, 0);

    clear = 1'b1;
    #1;
    sb_push(0); sb_pop("clear_ready", W'(bus.spawn_ready));
    step();
    clear = 1'b0;
    step();
    sb_push(0); sb_pop("clear_active", W'(active_cnt));
    sb_push(1); sb_pop("clear_ready_after", W'(bus.spawn_ready));

    // Escape toward MIN_C at speed 5
    spawn(100);
    speed = 4'd5;
    for (int i = 0; i < 127; i++) tick();
    speed = 4'd0;
    tick();
    sb_push(0); sb_pop("speed0_escape", W'(bus.escape));
    sb_push(0); sb_pop("speed0_esccnt", W'(bus.escape_cnt));
    pix_query("esc_at148", 148, 100, 1, 0, 0, 0);
    pix_query("esc_miss147", 147, 100, 0, 0, 0, 0);
    speed = 4'd5;
    tick();
    sb_push(1); sb_pop("esc_pulse", W'(bus.escape));
    sb_push(1); sb_pop("esc_cnt", W'(bus.escape_cnt));
    step();
    sb_push(0); sb_pop("esc_pulse_end", W'(bus.escape));
    sb_push(1); sb_pop("esc_cnt_hold", W'(bus.escape_cnt));
    sb_push(0); sb_pop("esc_active", W'(active_cnt));

    // Point hits: slots 2 and 5 overlap the query point
    do_clear();
    rows = '{300, 300, 100, 300, 300, 100};
    foreach (rows[k]) spawn(rows[k]);
    speed = 4'd3;
    tick();
    bus.hit_col   = 10'd800;
    bus.hit_row   = 10'd120;
    bus.hit_valid = 1'b1;
    step();
    sb_push(1); sb_pop("hit1_kill", W'(bus.kill));
    sb_push(2); sb_pop("hit1_idx", W'(bus.kill_idx));
    step();
    sb_push(1); sb_pop("hit2_kill", W'(bus.kill));
    sb_push(5); sb_pop("hit2_idx", W'(bus.kill_idx));
    step();
    sb_push(0); sb_pop("hit3_nokill", W'(bus.kill));
    bus.hit_valid = 1'b0;
    step();
    sb_push(4); sb_pop("hit_active", W'(active_cnt));

    // Hit on the same edge as an escaping tick: kill only
    do_clear();
    spawn(100);
    speed = 4'd15;
    for (int i = 0; i < 42; i++) tick();
    pix_query("pre_hitesc", 153, 100, 1, 0, 0, 0);
    bus.hit_col   = 10'd160;
    bus.hit_row   = 10'd110;
    bus.hit_valid = 1'b1;
    frame_tick    = 1'b1;
    step();
    frame_tick    = 1'b0;
    bus.hit_valid = 1'b0;
    sb_push(1); sb_pop("hitesc_kill", W'(bus.kill));
    sb_push(0); sb_pop("hitesc_idx", W'(bus.kill_idx));
    sb_push(0); sb_pop("hitesc_escape", W'(bus.escape));
    sb_push(0); sb_pop("hitesc_esccnt", W'(bus.escape_cnt));
    step();
    sb_push(0); sb_pop("hitesc_active", W'(active_cnt));

    // Pixel query offsets and box edges
    do_clear();
    spawn(100);
    pix_query("pix_in", 790, 110, 1, 0, 7, 10);
    pix_query("pix_right_miss", 833, 110, 0, 0, 0, 0);
    pix_query("pix_corner", 832, 139, 1, 0, 49, 39);
    pix_query("pix_bottom_miss", 790, 140, 0, 0, 0, 0);

    // enable=0 freezes motion, spawn and hit
    enable = 1'b0;
    speed  = 4'd5;
    bus.spawn_valid = 1'b1;
    bus.spawn_row   = 10'd500;
    bus.hit_col     = 10'd790;
    bus.hit_row     = 10'd110;
    bus.hit_valid   = 1'b1;
    frame_tick      = 1'b1;
    #1;
    sb_push(0); sb_pop("dis_ready", W'(bus.spawn_ready));
    for (int i = 0; i < 10; i++) step();
    sb_push(0); sb_pop("dis_kill", W'(bus.kill));
    frame_tick      = 1'b0;
    bus.hit_valid   = 1'b0;
    bus.spawn_valid = 1'b0;
    enable = 1'b1;
    pix_query("dis_nomove", 783, 100, 1, 0, 0, 0);
    sb_push(1); sb_pop("dis_active", W'(active_cnt));

    // Asynchronous reset mid-stream
    pix_query("prerst_pix", 790, 110, 1, 0, 7, 10);
    #2;
    rst = 1'b0;
    #1;
    reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step();
    pix_query("postrst_pix", 790, 110, 0, 0, 0, 0);
    sb_push(0); sb_pop("postrst_active", W'(active_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
